// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types and default sizing for the FFT bit-reversed to natural-order reorder stage.
package fft_bitrev_reorder_pkg;

    localparam int DEF_LOG2_N     = 6;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// Simple dual-port sample store for the reorder stage: synchronous write, registered read.
module fft_bitrev_reorder_ram #(
    parameter int ADDR_WIDTH = 7,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder of a bit-reversed FFT output stream into natural order, 1 sample/clk.
// Optional do_sop/do_eop frame markers are built only when FFT_REORDER_SOP_EN is defined.
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int LOG2_N     = DEF_LOG2_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  di_en,
    input  logic [DATA_WIDTH-1:0] di_re,
    input  logic [DATA_WIDTH-1:0] di_im,
    output logic                  do_en,
    output logic [DATA_WIDTH-1:0] do_re,
    output logic [DATA_WIDTH-1:0] do_im
`ifdef FFT_REORDER_SOP_EN
    ,
    output logic                  do_sop,
    output logic                  do_eop
`endif
);

    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] x);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = x[LOG2_N-1-i];
        end
        return r;
    endfunction

    logic [LOG2_N-1:0]     wr_cnt;
    logic                  wr_bank;
    logic [LOG2_N-1:0]     rd_cnt;
    logic                  rd_bank;
    logic [1:0]            full;
    rd_state_t             state;
    logic [WORD_WIDTH-1:0] rd_word;

    logic wr_last;
    logic rd_last;
    logic other_ready;

    assign wr_last = di_en & (&wr_cnt);
    assign rd_last = (state == READ) & (&rd_cnt);
    // The other bank counts as ready even if its full flag is only being set this edge.
    assign other_ready = full[~rd_bank] | (wr_last & (wr_bank != rd_bank));

    fft_bitrev_reorder_ram #(
        .ADDR_WIDTH(LOG2_N + 1),
        .WORD_WIDTH(WORD_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (di_en),
        .waddr({wr_bank, bitrev(wr_cnt)}),
        .wdata({di_re, di_im}),
        .raddr({rd_bank, rd_cnt}),
        .rdata(rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (di_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (&wr_cnt) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && (wr_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end else if (rd_last && (rd_bank == 1'(b))) begin
                    full[b] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            do_en   <= 1'b0;
`ifdef FFT_REORDER_SOP_EN
            do_sop  <= 1'b0;
            do_eop  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    do_en <= 1'b0;
`ifdef FFT_REORDER_SOP_EN
                    do_sop <= 1'b0;
                    do_eop <= 1'b0;
`endif
                    if (full[rd_bank]) begin
                        state  <= READ;
                        rd_cnt <= '0;
                    end
                end
                READ: begin
                    do_en  <= 1'b1;
                    rd_cnt <= rd_cnt + 1'b1;
`ifdef FFT_REORDER_SOP_EN
                    do_sop <= (rd_cnt == '0);
                    do_eop <= &rd_cnt;
`endif
                    if (&rd_cnt) begin
                        rd_bank <= ~rd_bank;
                        if (!other_ready) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    do_en <= 1'b0;
                end
            endcase
        end
    end

    // The RAM read register carries the sample; outputs are gated so they read 0 when idle.
    assign do_re = do_en ? rd_word[WORD_WIDTH-1:DATA_WIDTH] : '0;
    assign do_im = do_en ? rd_word[DATA_WIDTH-1:0]          : '0;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder at N=8, with an optional FFT_REORDER_SOP_EN build.
module tb_fft_bitrev_reorder;

    localparam int LOG2_N = 3;
    localparam int N      = 8;
    localparam int DW     = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          di_en;
    logic [DW-1:0] di_re;
    logic [DW-1:0] di_im;
    logic          do_en;
    logic [DW-1:0] do_re;
    logic [DW-1:0] do_im;
`ifdef FFT_REORDER_SOP_EN
    logic          do_sop;
    logic          do_eop;
`endif

    fft_bitrev_reorder #(
        .LOG2_N    (LOG2_N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
`ifdef FFT_REORDER_SOP_EN
        ,
        .do_sop(do_sop),
        .do_eop(do_eop)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            idx;
        int            due;
    } exp_t;

    exp_t          q[$];
    int            checks   = 0;
    int            failures = 0;
    int            prev_end = -100;
    logic [DW-1:0] fr_re [N];
    logic [DW-1:0] fr_im [N];
    int            fr_cnt   = 0;
    logic          armed    = 1'b0;

    function automatic int ref_rev(input int v);
        int r = 0;
        int x = v;
        for (int b = 0; b < LOG2_N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        di_en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept one sample; when a frame completes, queue its natural-order outputs with due cycles.
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int k;
        int start;
        di_en = 1'b1;
        di_re = re;
        di_im = im;
        @(posedge clk);
        #1;
        di_en = 1'b0;
        fr_re[fr_cnt] = re;
        fr_im[fr_cnt] = im;
        fr_cnt++;
        if (fr_cnt == N) begin
            k     = cyc;
            start = (k <= prev_end) ? prev_end + 1 : k + 2;
            for (int j = 0; j < N; j++) begin
                q.push_back('{fr_re[ref_rev(j)], fr_im[ref_rev(j)], j, start + j});
            end
            prev_end = start + N - 1;
            fr_cnt   = 0;
        end
    endtask

    task automatic send_frame(input int base);
        for (int i = 0; i < N; i++) begin
            send(DW'(base + i), DW'(-(base + i)));
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        while (q.size() > 0 && q[$].due > cyc) begin
            void'(q.pop_back());
        end
        fr_cnt   = 0;
        prev_end = -100;
        idle(n);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (do_en === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got re=%0h with nothing expected (cycle %0d)", do_re, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("do_re", 32'(do_re), 32'(e.re));
                    check("do_im", 32'(do_im), 32'(e.im));
                    check("due_cycle", cyc, e.due);
`ifdef FFT_REORDER_SOP_EN
                    check("do_sop", 32'(do_sop), 32'(e.idx == 0));
                    check("do_eop", 32'(do_eop), 32'(e.idx == N - 1));
`endif
                end
            end else begin
                check("idle_do_en", 32'(do_en), 32'd0);
                check("idle_do_re", 32'(do_re), 32'd0);
                check("idle_do_im", 32'(do_im), 32'd0);
`ifdef FFT_REORDER_SOP_EN
                check("idle_sop_eop", {30'd0, do_sop, do_eop}, 32'd0);
`endif
                if (q.size() > 0 && q[0].due <= cyc) begin
                    exp_t m;
                    m = q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_output: got do_en=0 expected index %0d re=%0h (cycle %0d)", m.idx, m.re, cyc);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        @(posedge clk);
        #1;
        armed = 1'b1;
        idle(2);
        check("reset_do_en", 32'(do_en), 32'd0);
        rst = 1'b0;

        // single frame, then three back-to-back frames
        send_frame(0);
        idle(12);
        for (int f = 0; f < 3; f++) begin
            send_frame(f * N);
        end
        idle(12);

        // frame with a gap after every sample
        for (int i = 0; i < N; i++) begin
            send(DW'(i), DW'(-i));
            idle(1);
        end
        idle(12);

        // reset after a partial frame, then a clean frame
        for (int i = 0; i < 5; i++) begin
            send(DW'(100 + i), DW'(-(100 + i)));
        end
        do_reset(3);
        send_frame(0);
        idle(12);

        // reset while output index 3 is on the port
        send_frame(40);
        idle(5);
        do_reset(2);
        idle(10);

        // random data with random gaps
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) begin
                send(DW'($urandom), DW'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    idle($urandom_range(1, 3));
                end
            end
        end

        for (int t = 0; t < 200 && q.size() > 0; t++) begin
            idle(1);
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d outputs still pending expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
